inst_fetch_unit: RTL

//  Instruction fetch stage directly upstream of the instruction memory (16-bit word address,
//  32-bit combinational read data). Holds the PC, drives the memory address, captures the

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fifo.sv | 63 ++++++
 rtl/inst_fetch_unit.sv | 69 ++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-path widths, reset PC default and the queue entry layout.
// Imported by the fetch top level and its instruction queue.
package inst_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-address increment; wraps 16'hFFFF -> 16'h0000 by construction.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small circular queue of {pc, instr} entries between fetch and decode.
// Flush clears occupancy and pointers in one edge; storage is not reset.
module inst_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop & ~empty & ~flush;
    // A full queue still accepts a write when the head leaves on the same edge.
    do_push = push & (~full | do_pop) & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register, imem addressing, and a decode-facing queue
// with valid/ready handshake; execute redirects flush the queue and reload PC.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [15:0]            redirect_pc,
  output logic [15:0]            imem_addr,
  input  logic [31:0]            imem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [15:0]            out_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  logic [ADDR_W-1:0] pc;
  logic              pop;
  logic              push;
  logic              q_empty;
  logic              q_full;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  always_comb begin
    pop      = out_valid & out_ready;
    push     = fetch_en & ~redirect_valid & (~q_full | pop);
    wr_entry = '{pc: pc, instr: imem_data};
  end

  // Fetch stage: PC register; redirect wins over any push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc_incr(pc);
  end

  assign imem_addr = pc;

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop & ~redirect_valid),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  // Decode side: head fields are zeroed whenever the queue is empty so stale
  // storage never reaches the outputs (including straight after reset).
  always_comb begin
    out_valid = ~q_empty;
    out_instr = out_valid ? head.instr : '0;
    out_pc    = out_valid ? head.pc    : '0;
  end

endmodule
